// File: rtl/ddr_cmd_pkg.sv
// Shared definitions for the DDR command issuer: chip command bit indices, FSM state
// encoding and bank-table lookup result.
package ddr_cmd_pkg;

  localparam int unsigned CMD_WIDTH = 19;
  localparam int unsigned CMD_ACT   = 0;
  localparam int unsigned CMD_PR    = 11;
  localparam int unsigned CMD_PRA   = 12;
  localparam int unsigned CMD_RD    = 13;
  localparam int unsigned CMD_REF   = 15;
  localparam int unsigned CMD_WR    = 18;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StPre     = 4'd1;
  localparam logic [3:0] StWaitRp  = 4'd2;
  localparam logic [3:0] StAct     = 4'd3;
  localparam logic [3:0] StWaitRcd = 4'd4;
  localparam logic [3:0] StRdWr    = 4'd5;
  localparam logic [3:0] StWaitCcd = 4'd6;
  localparam logic [3:0] StRefPra  = 4'd7;
  localparam logic [3:0] StRefWrp  = 4'd8;
  localparam logic [3:0] StRef     = 4'd9;
  localparam logic [3:0] StWaitRfc = 4'd10;

  typedef enum logic [1:0] {
    LkClosed = 2'd0,
    LkHit    = 2'd1,
    LkMiss   = 2'd2
  } lookup_e;

  function automatic logic [CMD_WIDTH-1:0] cmd_bit(input int unsigned idx);
    return CMD_WIDTH'(1) << idx;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_bank_table.sv
// Per-bank open flag and open-row store; classifies a lookup as hit, closed or miss.
module ddr_bank_table
  import ddr_cmd_pkg::*;
#(
  parameter int unsigned NumBanks = 4,
  parameter int unsigned RowWidth = 17,
  localparam int unsigned BankW   = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [BankW-1:0]    lk_bank_i,
  input  logic [RowWidth-1:0] lk_row_i,
  output lookup_e             lk_result_o,
  output logic                any_open_o,
  input  logic                set_i,
  input  logic [BankW-1:0]    set_bank_i,
  input  logic [RowWidth-1:0] set_row_i,
  input  logic                clr_i,
  input  logic [BankW-1:0]    clr_bank_i,
  input  logic                clr_all_i
);

  logic [NumBanks-1:0] open_q, open_d;
  logic [RowWidth-1:0] row_q [NumBanks];
  logic [RowWidth-1:0] row_d [NumBanks];

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (clr_i) begin
      open_d[clr_bank_i] = 1'b0;
    end
    if (set_i) begin
      open_d[set_bank_i] = 1'b1;
      row_d[set_bank_i]  = set_row_i;
    end
    if (clr_all_i) begin
      open_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q <= '0;
      for (int i = 0; i < NumBanks; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  always_comb begin
    if (!open_q[lk_bank_i]) begin
      lk_result_o = LkClosed;
    end else if (row_q[lk_bank_i] == lk_row_i) begin
      lk_result_o = LkHit;
    end else begin
      lk_result_o = LkMiss;
    end
  end

  assign any_open_o = |open_q;

endmodule

// File: rtl/ddr_cmd_issuer.sv
// Open-page DRAM command issuer enforcing tRCD/tRP/tCCD; periodic refresh is compiled in
// when AUTO_REFRESH_EN is defined.
module ddr_cmd_issuer
  import ddr_cmd_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = 17,
  parameter int unsigned BANKGROUPS    = 2,
  parameter int unsigned BANKSPERGROUP = 2,
  parameter int unsigned COLS          = 1024,
  parameter int unsigned TRCD          = 4,
  parameter int unsigned TRP           = 4,
  parameter int unsigned TCCD          = 4,
  parameter int unsigned TREFI         = 1560,
  parameter int unsigned TRFC          = 32,
  localparam int unsigned CADDRWIDTH   = $clog2(COLS),
  localparam int unsigned BGWIDTH      = $clog2(BANKGROUPS),
  localparam int unsigned BAWIDTH      = $clog2(BANKSPERGROUP)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BGWIDTH:0]      req_bg,
  input  logic [BAWIDTH:0]      req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [CADDRWIDTH-1:0] req_col,
  output logic [CMD_WIDTH-1:0]  commands,
  output logic [BGWIDTH:0]      bg,
  output logic [BAWIDTH:0]      ba,
  output logic [ADDRWIDTH-1:0]  row,
  output logic [CADDRWIDTH-1:0] column,
  output logic                  issue_valid,
  output logic                  issue_write,
  output logic                  busy
);

  localparam int unsigned NumBanks = BANKGROUPS * BANKSPERGROUP;
  localparam int unsigned BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned CntMax   = max_u(max_u(TRCD, TRP), max_u(TCCD, TRFC));
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  logic [3:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [BGWIDTH:0]      bg_q, bg_d;
  logic [BAWIDTH:0]      ba_q, ba_d;
  logic [ADDRWIDTH-1:0]  row_q, row_d;
  logic [CADDRWIDTH-1:0] col_q, col_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  issue_write_q, issue_write_d;

  logic                  rq_write_q, rq_write_d;
  logic [BGWIDTH:0]      rq_bg_q, rq_bg_d;
  logic [BAWIDTH:0]      rq_ba_q, rq_ba_d;
  logic [BankW-1:0]      rq_bank_q, rq_bank_d;
  logic [ADDRWIDTH-1:0]  rq_row_q, rq_row_d;
  logic [CADDRWIDTH-1:0] rq_col_q, rq_col_d;

  logic                  in_range, idle;
  logic [BGWIDTH:0]      in_bg;
  logic [BAWIDTH:0]      in_ba;
  logic [BankW-1:0]      in_bank;
  logic                  cur_write;
  logic [BGWIDTH:0]      cur_bg;
  logic [BAWIDTH:0]      cur_ba;
  logic [BankW-1:0]      cur_bank;
  logic [ADDRWIDTH-1:0]  cur_row;
  logic [CADDRWIDTH-1:0] cur_col;

  lookup_e               lk_result;
  logic                  any_open, tbl_set, tbl_clr, tbl_clr_all;
  logic                  do_act, do_rdwr;
  logic                  ref_pend_q, ref_pend_d, ref_done;

  // Out-of-range bank group or bank is folded onto bank 0, including the address driven out.
  assign in_range = (32'(req_bg) < BANKGROUPS) && (32'(req_ba) < BANKSPERGROUP);
  assign in_bg    = in_range ? req_bg : '0;
  assign in_ba    = in_range ? req_ba : '0;
  assign in_bank  = in_range ? BankW'(32'(req_bg) * BANKSPERGROUP + 32'(req_ba)) : '0;

  // In IDLE the request is issued in the capture cycle, so use the live inputs there.
  assign idle      = (state_q == StIdle);
  assign cur_write = idle ? req_write : rq_write_q;
  assign cur_bg    = idle ? in_bg     : rq_bg_q;
  assign cur_ba    = idle ? in_ba     : rq_ba_q;
  assign cur_bank  = idle ? in_bank   : rq_bank_q;
  assign cur_row   = idle ? req_row   : rq_row_q;
  assign cur_col   = idle ? req_col   : rq_col_q;

  ddr_bank_table #(
    .NumBanks (NumBanks),
    .RowWidth (ADDRWIDTH)
  ) u_bank_table (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .lk_bank_i   (in_bank),
    .lk_row_i    (req_row),
    .lk_result_o (lk_result),
    .any_open_o  (any_open),
    .set_i       (tbl_set),
    .set_bank_i  (cur_bank),
    .set_row_i   (cur_row),
    .clr_i       (tbl_clr),
    .clr_bank_i  (in_bank),
    .clr_all_i   (tbl_clr_all)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = '0;
    bg_d          = bg_q;
    ba_d          = ba_q;
    row_d         = row_q;
    col_d         = col_q;
    issue_valid_d = 1'b0;
    issue_write_d = issue_write_q;
    rq_write_d    = rq_write_q;
    rq_bg_d       = rq_bg_q;
    rq_ba_d       = rq_ba_q;
    rq_bank_d     = rq_bank_q;
    rq_row_d      = rq_row_q;
    rq_col_d      = rq_col_q;
    tbl_set       = 1'b0;
    tbl_clr       = 1'b0;
    tbl_clr_all   = 1'b0;
    ref_done      = 1'b0;
    do_act        = 1'b0;
    do_rdwr       = 1'b0;

    case (state_q)
      StIdle: begin
`ifdef AUTO_REFRESH_EN
        if (ref_pend_q) begin
          tbl_clr_all = 1'b1;
          if (any_open) begin
            cmd_d   = cmd_bit(CMD_PRA);
            cnt_d   = CntW'(TRP);
            state_d = StRefPra;
          end else begin
            cmd_d   = cmd_bit(CMD_REF);
            cnt_d   = CntW'(TRFC);
            state_d = StRef;
          end
        end else
`endif
        if (req_valid && ready_q) begin
          rq_write_d = req_write;
          rq_bg_d    = in_bg;
          rq_ba_d    = in_ba;
          rq_bank_d  = in_bank;
          rq_row_d   = req_row;
          rq_col_d   = req_col;
          case (lk_result)
            LkHit:    do_rdwr = 1'b1;
            LkClosed: do_act  = 1'b1;
            default: begin
              cmd_d   = cmd_bit(CMD_PR);
              bg_d    = cur_bg;
              ba_d    = cur_ba;
              tbl_clr = 1'b1;
              cnt_d   = CntW'(TRP);
              state_d = StPre;
            end
          endcase
        end
      end
      StPre, StWaitRp: begin
        if (cnt_q == CntW'(1)) begin
          do_act = 1'b1;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWaitRp;
        end
      end
      StAct, StWaitRcd: begin
        if (cnt_q == CntW'(1)) begin
          do_rdwr = 1'b1;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWaitRcd;
        end
      end
      StRdWr, StWaitCcd: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWaitCcd;
        end
      end
`ifdef AUTO_REFRESH_EN
      StRefPra, StRefWrp: begin
        if (cnt_q == CntW'(1)) begin
          cmd_d       = cmd_bit(CMD_REF);
          tbl_clr_all = 1'b1;
          cnt_d       = CntW'(TRFC);
          state_d     = StRef;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StRefWrp;
        end
      end
      StRef, StWaitRfc: begin
        if (cnt_q == CntW'(1)) begin
          ref_done = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWaitRfc;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (do_act) begin
      cmd_d   = cmd_bit(CMD_ACT);
      bg_d    = cur_bg;
      ba_d    = cur_ba;
      row_d   = cur_row;
      tbl_set = 1'b1;
      cnt_d   = CntW'(TRCD);
      state_d = StAct;
    end

    // The CCD countdown starts one short so ready reopens a cycle before the next slot.
    if (do_rdwr) begin
      cmd_d         = cur_write ? cmd_bit(CMD_WR) : cmd_bit(CMD_RD);
      bg_d          = cur_bg;
      ba_d          = cur_ba;
      col_d         = cur_col;
      issue_valid_d = 1'b1;
      issue_write_d = cur_write;
      if (TCCD <= 1) begin
        state_d = StIdle;
      end else begin
        cnt_d   = CntW'(TCCD - 1);
        state_d = StRdWr;
      end
    end
  end

`ifdef AUTO_REFRESH_EN
  localparam int unsigned RefW = (TREFI > 1) ? $clog2(TREFI) : 1;

  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic            ref_wrap;

  // A wrap while refresh is already pending is absorbed, not queued.
  always_comb begin
    ref_wrap   = (ref_cnt_q == RefW'(TREFI - 1));
    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + RefW'(1);
    ref_pend_d = (ref_pend_q & ~ref_done) | ref_wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end
`else
  logic unused_cfg;

  assign ref_pend_q = 1'b0;
  assign ref_pend_d = 1'b0;
  assign unused_cfg = ^{TREFI, any_open, ref_done};
`endif

  always_comb begin
    ready_d = (state_d == StIdle) && !ref_pend_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      cmd_q         <= '0;
      bg_q          <= '0;
      ba_q          <= '0;
      row_q         <= '0;
      col_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_write_q <= 1'b0;
      rq_write_q    <= 1'b0;
      rq_bg_q       <= '0;
      rq_ba_q       <= '0;
      rq_bank_q     <= '0;
      rq_row_q      <= '0;
      rq_col_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      cmd_q         <= cmd_d;
      bg_q          <= bg_d;
      ba_q          <= ba_d;
      row_q         <= row_d;
      col_q         <= col_d;
      issue_valid_q <= issue_valid_d;
      issue_write_q <= issue_write_d;
      rq_write_q    <= rq_write_d;
      rq_bg_q       <= rq_bg_d;
      rq_ba_q       <= rq_ba_d;
      rq_bank_q     <= rq_bank_d;
      rq_row_q      <= rq_row_d;
      rq_col_q      <= rq_col_d;
    end
  end

  assign req_ready   = ready_q;
  assign commands    = cmd_q;
  assign bg          = bg_q;
  assign ba          = ba_q;
  assign row         = row_q;
  assign column      = col_q;
  assign issue_valid = issue_valid_q;
  assign issue_write = issue_write_q;
  assign busy        = (state_q != StIdle);

endmodule
